// File: rtl/qsfp_hpd_sequencer.sv
// qsfp_hpd_sequencer
//   Turns the raw QSFP ModPrsL pin into a qualified hot-plug-detect and owns
//   the QSFP ResetL pin. Sequence: debounce insertion, pulse ResetL low,
//   wait out module init time, then assert hpd.
//
// Ports:
//   system_clock    in   system clock (all logic in this domain)
//   system_reset_n  in   synchronous, active-low reset
//   modprsl         in   raw QSFP ModPrsL, asynchronous, low = module present
//   rearm           in   single-cycle pulse requesting a fresh reset/init
//   qsfp_resetl     out  QSFP ResetL, low = module held in reset
//   hpd             out  qualified hot-plug detect
//   state           out  FSM state: 0 ABSENT, 1 DEBOUNCE, 2 RESET, 3 INIT, 4 READY
//
// Optional build macro:
//   QSFP_HPD_REMOVAL_DEBOUNCE_EN  when defined, removal in READY must persist
//                                 for DEBOUNCE_CYCLES before hpd drops.
module qsfp_hpd_sequencer #(
  parameter int CLOCK_FREQUENCY = 200_000_000,
  parameter int DEBOUNCE_US     = 10000,
  parameter int RESET_PULSE_US  = 10,
  parameter int INIT_US         = 2000000
) (
  input  logic       system_clock,
  input  logic       system_reset_n,
  input  logic       modprsl,
  input  logic       rearm,
  output logic       qsfp_resetl,
  output logic       hpd,
  output logic [2:0] state
);

  localparam int CYC_PER_US = CLOCK_FREQUENCY / 1_000_000;

  localparam int DEBOUNCE_RAW = CYC_PER_US * DEBOUNCE_US;
  localparam int RESET_RAW    = CYC_PER_US * RESET_PULSE_US;
  localparam int INIT_RAW     = CYC_PER_US * INIT_US;

  // A zero-length phase would make the terminal compare unreachable.
  localparam int DEBOUNCE_CYCLES = (DEBOUNCE_RAW < 1) ? 1 : DEBOUNCE_RAW;
  localparam int RESET_CYCLES    = (RESET_RAW < 1) ? 1 : RESET_RAW;
  localparam int INIT_CYCLES     = (INIT_RAW < 1) ? 1 : INIT_RAW;

  localparam int MAX_DR     = (DEBOUNCE_CYCLES > RESET_CYCLES) ? DEBOUNCE_CYCLES : RESET_CYCLES;
  localparam int MAX_CYCLES = (MAX_DR > INIT_CYCLES) ? MAX_DR : INIT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST     = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_ABSENT   = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_RESET    = 3'd2,
    ST_INIT     = 3'd3,
    ST_READY    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic modprsl_p0, modprsl_p1;
  logic present;

  // Stage p0/p1: two-flop synchronizer for the asynchronous ModPrsL pin.
  // Reset to 1 so the module reads as absent until proven otherwise.
  always_ff @(posedge system_clock) begin
    if (!system_reset_n) begin
      modprsl_p0 <= 1'b1;
      modprsl_p1 <= 1'b1;
    end else begin
      modprsl_p0 <= modprsl;
      modprsl_p1 <= modprsl_p0;
    end
  end

  assign present = ~modprsl_p1;

  // State and shared phase counter.
  always_ff @(posedge system_clock) begin
    if (!system_reset_n) begin
      state_q <= ST_ABSENT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The counter is cleared on every state change so each
  // phase starts counting from zero and the counter can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ABSENT: begin
        if (present) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!present) begin
          state_d = ST_ABSENT;
          cnt_d   = '0;
        end else if (cnt_q == DEBOUNCE_LAST) begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RESET: begin
        if (!present) begin
          state_d = ST_ABSENT;
          cnt_d   = '0;
        end else if (cnt_q == RESET_LAST) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_INIT: begin
        if (!present) begin
          state_d = ST_ABSENT;
          cnt_d   = '0;
        end else if (rearm) begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end else if (cnt_q == INIT_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_READY: begin
`ifdef QSFP_HPD_REMOVAL_DEBOUNCE_EN
        // Counter tracks consecutive absent cycles; a pending removal takes
        // priority over rearm, matching the immediate-removal behaviour.
        if (!present) begin
          if (cnt_q == DEBOUNCE_LAST) begin
            state_d = ST_ABSENT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (rearm) begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end else begin
          cnt_d = '0;
        end
`else
        if (!present) begin
          state_d = ST_ABSENT;
          cnt_d   = '0;
        end else if (rearm) begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
`endif
      end
      default: begin
        state_d = ST_ABSENT;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore decode of the registered state.
  assign qsfp_resetl = (state_q == ST_INIT) || (state_q == ST_READY);
  assign hpd         = (state_q == ST_READY);
  assign state       = state_q;

endmodule

// File: tb/tb_qsfp_hpd_sequencer.sv
// tb_qsfp_hpd_sequencer
//   Table-driven bench for qsfp_hpd_sequencer with 1 MHz clock parameters:
//   DEBOUNCE=4, RESET=3, INIT=5 cycles. Each table record gives the inputs
//   applied before a clock edge and the outputs expected just after it.
//   Hand-written sequences cover the insertion glitch, counter restart,
//   mid-sequence reset and (with the macro) removal debounce.
module tb_qsfp_hpd_sequencer;

  logic       clk;
  logic       rst_n;
  logic       modprsl;
  logic       rearm;
  logic       qsfp_resetl;
  logic       hpd;
  logic [2:0] state;

  qsfp_hpd_sequencer #(
    .CLOCK_FREQUENCY(1_000_000),
    .DEBOUNCE_US    (4),
    .RESET_PULSE_US (3),
    .INIT_US        (5)
  ) dut (
    .system_clock  (clk),
    .system_reset_n(rst_n),
    .modprsl       (modprsl),
    .rearm         (rearm),
    .qsfp_resetl   (qsfp_resetl),
    .hpd           (hpd),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       modprsl;
    logic       rearm;
    logic [2:0] st;
    logic       rl;
    logic       h;
  } vec_t;

  vec_t vecs[80];
  int   nv;
  int   n_pass;
  int   n_total;
  int   n_fail;

  task automatic add(input logic r, input logic m, input logic ra,
                     input logic [2:0] st, input logic rl, input logic h);
    vecs[nv].rst_n   = r;
    vecs[nv].modprsl = m;
    vecs[nv].rearm   = ra;
    vecs[nv].st      = st;
    vecs[nv].rl      = rl;
    vecs[nv].h       = h;
    nv++;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st,
                            input logic rl, input logic h);
    check({tag, "_state"}, 8'(state), 8'(st));
    check({tag, "_resetl"}, 8'(qsfp_resetl), 8'(rl));
    check({tag, "_hpd"}, 8'(hpd), 8'(h));
  endtask

  initial begin
    logic [2:0] st;
    logic       saw_bad;
    nv      = 0;
    n_pass  = 0;
    n_total = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    modprsl = 1'b0;
    rearm   = 1'b0;

    // Reset held 3 cycles with the module present.
    repeat (3) add(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    // Clean insertion: E0..E14. A rearm at E3 lands in DEBOUNCE and is ignored.
    for (int e = 0; e <= 14; e++) begin
      if (e < 2)       st = 3'd0;
      else if (e < 6)  st = 3'd1;
      else if (e < 9)  st = 3'd2;
      else if (e < 14) st = 3'd3;
      else             st = 3'd4;
      add(1'b1, 1'b0, (e == 3), st, (e >= 9), (e == 14));
    end
    repeat (2) add(1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
    // Rearm in READY: ResetL low for 3 cycles, hpd back 8 edges after the pulse.
    for (int k = 0; k <= 8; k++) begin
      if (k < 3)      st = 3'd2;
      else if (k < 8) st = 3'd3;
      else            st = 3'd4;
      add(1'b1, 1'b0, (k == 0), st, (k >= 3), (k == 8));
    end
    add(1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
    // Removal in READY.
`ifdef QSFP_HPD_REMOVAL_DEBOUNCE_EN
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) add(1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1);
      else       add(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    end
`else
    for (int k = 0; k <= 2; k++) begin
      if (k < 2) add(1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1);
      else       add(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    end
`endif
    repeat (3) add(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    for (int i = 0; i < nv; i++) begin
      rst_n   = vecs[i].rst_n;
      modprsl = vecs[i].modprsl;
      rearm   = vecs[i].rearm;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].rl, vecs[i].h);
    end
    rearm = 1'b0;

    // Insertion glitch: present for 3 sampled cycles, then removed.
    modprsl = 1'b0;
    tick(); tick(); tick();
    check("glitch_debounce_entry", 8'(state), 8'd1);
    modprsl = 1'b1;
    saw_bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (hpd !== 1'b0 || qsfp_resetl !== 1'b0 || state == 3'd2) saw_bad = 1'b1;
    end
    check("glitch_no_progress", 8'(saw_bad), 8'd0);
    check_outs("glitch_end", 3'd0, 1'b0, 1'b0);
    tick(); tick();

    // Re-insertion: counting must restart from zero.
    modprsl = 1'b0;
    for (int e = 0; e <= 5; e++) tick();
    check("reinsert_e5_state", 8'(state), 8'd1);
    tick();
    check("reinsert_e6_state", 8'(state), 8'd2);
    for (int e = 7; e <= 9; e++) tick();
    check_outs("reinsert_e9", 3'd3, 1'b1, 1'b0);

    // Mid-sequence reset while in INIT.
    rst_n = 1'b0;
    tick();
    check_outs("midreset", 3'd0, 1'b0, 1'b0);
    tick();
    check_outs("midreset_hold", 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int e = 0; e <= 13; e++) tick();
    check_outs("restart_e13", 3'd3, 1'b1, 1'b0);
    tick();
    check_outs("restart_e14", 3'd4, 1'b1, 1'b1);

`ifdef QSFP_HPD_REMOVAL_DEBOUNCE_EN
    // Two-cycle removal glitch must not drop hpd.
    modprsl = 1'b1;
    tick(); tick();
    modprsl = 1'b0;
    saw_bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (hpd !== 1'b1) saw_bad = 1'b1;
    end
    check("removal_glitch_hpd_held", 8'(saw_bad), 8'd0);
    // Sustained removal: hpd drops at E5.
    modprsl = 1'b1;
    for (int k = 0; k <= 4; k++) tick();
    check("removal_e4_hpd", 8'(hpd), 8'd1);
    tick();
    check_outs("removal_e5", 3'd0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
